// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (line low)
// DATA   | shifting data bits, LSB first
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit(s), line high
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int CLK_RATE  = 8,
    parameter int BAUD_RATE = 1,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 outgoing_data,
    output logic                 tx_done
);

    localparam int CLK_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int CNT_W       = $clog2(CLK_PER_BIT + 1);
    localparam int IDX_W       = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLK_PER_BIT < 1) begin : g_bad_clk_per_bit
        $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 1");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic                 baud_tick;
    logic                 line_nxt;
    logic                 done_nxt;

    assign baud_tick = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick && bit_idx == DATA_LAST) begin
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick && bit_idx == STOP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line value is chosen from the state being entered so the pin register changes on the same edge.
    always_comb begin
        ready    = (state == S_IDLE);
        done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
        line_nxt = 1'b1;
        case (state_nxt)
            S_START:  line_nxt = 1'b0;
            S_DATA:   line_nxt = (state == S_DATA && baud_tick) ? shift[1] : shift[0];
            S_PARITY: line_nxt = parity_bit;
            default:  line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            parity_bit    <= 1'b0;
            outgoing_data <= 1'b1;
            tx_done       <= 1'b0;
        end else begin
            outgoing_data <= line_nxt;
            tx_done       <= done_nxt;
            if (state == S_IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (data_valid) begin
                    shift      <= data;
                    parity_bit <= (PARITY == 1) ? ~^data : ^data;
                end
            end else if (baud_tick) begin
                baud_cnt <= '0;
                if (state != state_nxt) begin
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
                if (state == S_DATA) begin
                    shift <= shift >> 1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different parity/stop settings, checked against a
// frame model built from the bit list of each word.
module tb_uart_tx;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0][7:0] data = '0;
    logic [3:0]      valid = '0;
    logic [3:0]      line;
    logic [3:0]      rdy;
    logic [3:0]      done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .CLK_RATE(8), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .reset(reset), .data(data[0]), .data_valid(valid[0]),
        .ready(rdy[0]), .outgoing_data(line[0]), .tx_done(done[0]));
    uart_tx #(.DATA_BITS(8), .CLK_RATE(8), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .data(data[1]), .data_valid(valid[1]),
        .ready(rdy[1]), .outgoing_data(line[1]), .tx_done(done[1]));
    uart_tx #(.DATA_BITS(8), .CLK_RATE(8), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .data(data[2]), .data_valid(valid[2]),
        .ready(rdy[2]), .outgoing_data(line[2]), .tx_done(done[2]));
    uart_tx #(.DATA_BITS(8), .CLK_RATE(8), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .data(data[3]), .data_valid(valid[3]),
        .ready(rdy[3]), .outgoing_data(line[3]), .tx_done(done[3]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int par_of(input int idx);
        case (idx)
            1:       return 2;
            2:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int idx);
        return (idx == 3) ? 2 : 1;
    endfunction

    // Expected line, one bit per clock after the accept edge; returns frame length in cycles.
    function automatic int build_frame(input logic [7:0] w, input int par, input int stp,
                                       output logic [127:0] bits);
        logic seq[$];
        int   ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            seq.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par == 2) seq.push_back(ones % 2 == 1);
        if (par == 1) seq.push_back(ones % 2 == 0);
        for (int i = 0; i < stp; i++) seq.push_back(1'b1);
        bits = '0;
        for (int k = 0; k < seq.size() * 8; k++) bits[k] = seq[k / 8];
        return seq.size() * 8;
    endfunction

    // Starts at a negedge, ends at the negedge after the IDLE re-entry edge (or one later if !keep).
    task automatic run_frame(input int idx, input logic [7:0] w, input bit keep);
        logic [127:0] exp_bits;
        logic [127:0] got_bits;
        int           len;
        int           busy_ready;
        int           busy_done;
        len = build_frame(w, par_of(idx), stop_of(idx), exp_bits);
        check("ready_pre", 128'(rdy[idx]), 128'(1));
        data[idx]  = w;
        valid[idx] = 1'b1;
        @(posedge clk);
        got_bits   = '0;
        busy_ready = 0;
        busy_done  = 0;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c < len) begin
                got_bits[c] = line[idx];
                busy_ready += int'(rdy[idx]);
                busy_done  += int'(done[idx]);
                data[idx]   = 8'($urandom);
                if (!keep) valid[idx] = 1'b0;
            end else begin
                check("end_line", 128'(line[idx]), 128'(1));
                check("end_ready", 128'(rdy[idx]), 128'(1));
                check("end_done", 128'(done[idx]), 128'(1));
            end
        end
        check("frame_bits", got_bits, exp_bits);
        check("busy_ready", 128'(busy_ready), 128'(0));
        check("busy_done", 128'(busy_done), 128'(0));
        if (!keep) begin
            @(negedge clk);
            check("idle_after", {126'(0), line[idx], done[idx]}, 128'(2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (line !== 4'hF || rdy !== 4'hF || done !== 4'h0) bad++;
        end
        check("reset_hold", 128'(bad), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", {116'(0), line, rdy, done}, {116'(0), 4'hF, 4'hF, 4'h0});

        run_frame(0, 8'hA5, 1'b0);
        run_frame(1, 8'hA5, 1'b0);
        run_frame(2, 8'hA5, 1'b0);

        run_frame(0, 8'h01, 1'b1);
        run_frame(0, 8'hFF, 1'b0);

        // Abort in the middle of data bit 3 (frame cycles 32..39), reset between clock edges.
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (35) @(negedge clk);
        check("abort_pre", 128'(line[0]), 128'(0));
        #2 reset = 1'b1;
        #1;
        check("abort_line", 128'(line[0]), 128'(1));
        check("abort_ready", 128'(rdy[0]), 128'(1));
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'h0 || line !== 4'hF) bad++;
        end
        check("abort_quiet", 128'(bad), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        run_frame(0, 8'h3C, 1'b0);

        for (int n = 0; n < 100; n++) begin
            run_frame(3, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        valid[3] = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 30; n++) begin
            int idx;
            idx = n % 3;
            run_frame(idx, 8'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
